// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit definitions: bus widths, access-size and FSM encodings, and byte-lane masks.
// The `DWIDTH / `AWIDTH_MEM macros are defined here once so every file sees the same widths.
`ifndef LSU_HEADER_DEFS
`define LSU_HEADER_DEFS
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH_MEM
`define AWIDTH_MEM 10
`endif
`endif

package load_store_unit_pkg;

    localparam int DWIDTH      = `DWIDTH;
    localparam int AWIDTH_MEM  = `AWIDTH_MEM;
    localparam int LANE_MASK_W = DWIDTH / 8;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } lsu_size_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } lsu_state_e;

    // One bit per byte lane touched by an access of the given size at the given offset.
    function automatic logic [LANE_MASK_W-1:0] lane_mask(input lsu_size_e size,
                                                         input logic [1:0] offset);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << offset;
            SIZE_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
            default:   lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-path lane extraction: picks the addressed byte/half out of a little-endian memory word
// and zero- or sign-extends it to the full data width.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [DWIDTH-1:0] i_word,
    input  lsu_size_e         i_size,
    input  logic [1:0]        i_offset,
    input  logic              i_unsigned,
    output logic [DWIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_byte_sign;
    logic        w_half_sign;

    assign w_byte      = i_word[{i_offset, 3'b000} +: 8];
    assign w_half      = i_word[{i_offset[1], 4'b0000} +: 16];
    assign w_byte_sign = ~i_unsigned & w_byte[7];
    assign w_half_sign = ~i_unsigned & w_half[15];

    always_comb begin
        case (i_size)
            SIZE_BYTE: o_data = {{(DWIDTH-8){w_byte_sign}}, w_byte};
            SIZE_HALF: o_data = {{(DWIDTH-16){w_half_sign}}, w_half};
            default:   o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a single-port data memory; sub-word stores use read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to suppress misaligned half/word accesses and pulse l_o_misalign.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                   m_clk,
    input  logic                   m_rst,
    input  logic                   l_i_rd,
    input  logic                   l_i_wr,
    input  logic [1:0]             l_i_size,
    input  logic                   l_i_unsigned,
    input  logic [`DWIDTH-1:0]     l_i_addr,
    input  logic [`DWIDTH-1:0]     l_i_wdata,
    output logic                   m_i_ce,
    output logic                   m_rd_en,
    output logic                   m_wr_en,
    output logic [`AWIDTH_MEM-1:0] alu_value_addr,
    output logic [`DWIDTH-1:0]     m_i_store_data,
    input  logic [`DWIDTH-1:0]     m_o_load_data,
    output logic [`DWIDTH-1:0]     l_o_rdata,
    output logic                   l_o_rvalid,
    output logic                   l_o_stall,
    output logic                   l_o_misalign
);

    lsu_state_e             r_state;
    lsu_state_e             w_state_next;
    lsu_size_e              w_size;
    logic                   w_req;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_sub_word;
    logic                   w_misalign;
    logic [1:0]             w_offset;
    logic [LANE_MASK_W-1:0] w_lane_mask;
    logic [DWIDTH-1:0]      w_byte_mask;
    logic [DWIDTH-1:0]      w_lane_data;
    logic [DWIDTH-1:0]      w_merged;
    logic [DWIDTH-1:0]      w_aligned;
    logic [DWIDTH-1:0]      w_store_data;
    logic                   w_ce;
    logic                   w_rd_en;
    logic                   w_wr_en;
    logic                   w_stall;
    logic                   w_capture;
    logic                   w_load_fire;
    logic                   w_unused;
    logic [DWIDTH-1:0]      r_merge;
    logic [DWIDTH-1:0]      r_rdata;
    logic                   r_rvalid;

    assign w_size     = lsu_size_e'(l_i_size);
    assign w_req      = l_i_rd | l_i_wr;
    assign w_is_store = l_i_wr;             // a simultaneous load is dropped in favour of the store
    assign w_is_load  = l_i_rd & ~l_i_wr;
    assign w_sub_word = (w_size == SIZE_BYTE) || (w_size == SIZE_HALF);
    assign w_unused   = &{1'b0, l_i_addr[DWIDTH-1:AWIDTH_MEM+2]};

    // Halves ignore addr[0] and words ignore addr[1:0]; traps are decided separately.
    always_comb begin
        case (w_size)
            SIZE_BYTE: w_offset = l_i_addr[1:0];
            SIZE_HALF: w_offset = {l_i_addr[1], 1'b0};
            default:   w_offset = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (w_size)
            SIZE_BYTE: w_misalign = 1'b0;
            SIZE_HALF: w_misalign = w_req & l_i_addr[0];
            default:   w_misalign = w_req & (l_i_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_lane_mask = lane_mask(w_size, w_offset);

    always_comb begin
        w_byte_mask = '0;
        for (int i = 0; i < LANE_MASK_W; i++) begin
            w_byte_mask[8*i +: 8] = {8{w_lane_mask[i]}};
        end
    end

    assign w_lane_data = (w_size == SIZE_BYTE) ? {4{l_i_wdata[7:0]}} : {2{l_i_wdata[15:0]}};
    assign w_merged    = (r_merge & ~w_byte_mask) | (w_lane_data & w_byte_mask);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_ce         = 1'b0;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_stall      = 1'b0;
        w_capture    = 1'b0;
        w_load_fire  = 1'b0;
        w_store_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_misalign) begin
                    w_ce = 1'b0;
                end else if (w_is_load) begin
                    w_ce        = 1'b1;
                    w_rd_en     = 1'b1;
                    w_load_fire = 1'b1;
                end else if (w_is_store && !w_sub_word) begin
                    w_ce         = 1'b1;
                    w_wr_en      = 1'b1;
                    w_store_data = l_i_wdata;
                end else if (w_is_store) begin
                    w_ce         = 1'b1;
                    w_rd_en      = 1'b1;
                    w_stall      = 1'b1;
                    w_capture    = 1'b1;
                    w_state_next = ST_RMW;
                end
            end
            ST_RMW: begin
                // Request inputs are still the held store, so any new request is not looked at here.
                w_ce         = 1'b1;
                w_wr_en      = 1'b1;
                w_store_data = w_merged;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Gating with m_rst keeps the memory quiet for the whole reset, including an aborted RMW.
    assign m_i_ce         = w_ce & m_rst;
    assign m_rd_en        = w_rd_en & m_rst;
    assign m_wr_en        = w_wr_en & m_rst;
    assign l_o_stall      = w_stall & m_rst;
    assign alu_value_addr = m_i_ce ? l_i_addr[AWIDTH_MEM+1:2] : '0;
    assign m_i_store_data = m_i_ce ? w_store_data : '0;

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    lsu_load_align u_load_align (
        .i_word     (m_o_load_data),
        .i_size     (w_size),
        .i_offset   (w_offset),
        .i_unsigned (l_i_unsigned),
        .o_data     (w_aligned)
    );

    // NOTE: the merge register is reset even though it is reloaded before every use,
    // so an aborted read-modify-write leaves no stale memory contents behind.
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_merge  <= '0;
        end else begin
            r_rvalid <= w_load_fire;
            if (w_load_fire) begin
                r_rdata <= w_aligned;
            end
            if (w_capture) begin
                r_merge <= m_o_load_data;
            end
        end
    end

    assign l_o_rdata  = r_rdata;
    assign l_o_rvalid = r_rvalid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign && (r_state == ST_IDLE);
        end
    end

    assign l_o_misalign = r_misalign;
`else
    assign l_o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic, scored against
// a byte-addressed memory model; a negedge monitor pops expected loads, writes and misalign pulses.
module tb_load_store_unit;

    localparam int NWORDS = 1024;

    typedef struct {
        logic [31:0] data;
        logic [31:0] idx;
        int          due;
    } exp_t;

    logic        m_clk = 1'b0;
    logic        m_rst;
    logic        l_i_rd;
    logic        l_i_wr;
    logic [1:0]  l_i_size;
    logic        l_i_unsigned;
    logic [31:0] l_i_addr;
    logic [31:0] l_i_wdata;
    logic        m_i_ce;
    logic        m_rd_en;
    logic        m_wr_en;
    logic [9:0]  alu_value_addr;
    logic [31:0] m_i_store_data;
    logic [31:0] m_o_load_data;
    logic [31:0] l_o_rdata;
    logic        l_o_rvalid;
    logic        l_o_stall;
    logic        l_o_misalign;

    logic [31:0] mem [0:NWORDS-1];
    logic        mem_load;
    logic [7:0]  ref_mem [0:4*NWORDS-1];

    exp_t load_q[$];
    exp_t write_q[$];
    exp_t mis_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    load_store_unit dut (
        .m_clk          (m_clk),
        .m_rst          (m_rst),
        .l_i_rd         (l_i_rd),
        .l_i_wr         (l_i_wr),
        .l_i_size       (l_i_size),
        .l_i_unsigned   (l_i_unsigned),
        .l_i_addr       (l_i_addr),
        .l_i_wdata      (l_i_wdata),
        .m_i_ce         (m_i_ce),
        .m_rd_en        (m_rd_en),
        .m_wr_en        (m_wr_en),
        .alu_value_addr (alu_value_addr),
        .m_i_store_data (m_i_store_data),
        .m_o_load_data  (m_o_load_data),
        .l_o_rdata      (l_o_rdata),
        .l_o_rvalid     (l_o_rvalid),
        .l_o_stall      (l_o_stall),
        .l_o_misalign   (l_o_misalign)
    );

    always #5 m_clk = ~m_clk;

    always @(posedge m_clk) cyc <= cyc + 1;

    // Data memory seen by the DUT: combinational read, write on the rising edge.
    always @(posedge m_clk) begin
        if (mem_load) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= 32'(i);
        end else if (m_i_ce && m_wr_en) begin
            mem[alu_value_addr] <= m_i_store_data;
        end
    end

    assign m_o_load_data = mem[alu_value_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic int eff_addr(input logic [31:0] addr, input int n);
        int a;
        a = int'(addr[11:0]);
        return a - (a % n);
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        int          n;
        int          ea;
        logic [31:0] v;
        n  = size_bytes(size);
        ea = eff_addr(addr, n);
        v  = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[ea+k]) << (8*k));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] wdata, output logic [31:0] word,
                               output logic [31:0] idx);
        int n;
        int ea;
        n  = size_bytes(size);
        ea = eff_addr(addr, n);
        for (int k = 0; k < n; k++) ref_mem[ea+k] = wdata[8*k +: 8];
        idx  = 32'(ea / 4);
        word = ref_word(ea / 4);
    endtask

    // Issues one request at posedge+1 and holds it while the DUT stalls.
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic has_exp, input logic [31:0] exp_val);
        int   n;
        int   issue;
        int   stalls;
        int   exp_stall;
        logic mis;
        logic st;
        exp_t e;
        n   = size_bytes(size);
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (rd || wr) && ((int'(addr[11:0]) % n) != 0);
`endif
        l_i_rd       = rd;
        l_i_wr       = wr;
        l_i_size     = size;
        l_i_unsigned = uns;
        l_i_addr     = addr;
        l_i_wdata    = wdata;
        issue        = cyc;
        exp_stall    = 0;
        e.data       = 32'h0;
        e.idx        = 32'h0;
        if (mis) begin
            e.due = issue + 1;
            mis_q.push_back(e);
        end else if (wr) begin
            model_store(addr, size, wdata, e.data, e.idx);
            e.due     = issue + ((n < 4) ? 1 : 0);
            exp_stall = (n < 4) ? 1 : 0;
            write_q.push_back(e);
        end else if (rd) begin
            e.data = has_exp ? exp_val : model_load(addr, size, uns);
            e.due  = issue + 1;
            load_q.push_back(e);
        end
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge m_clk);
            st = l_o_stall;
            if (mis) check("trap_no_access", 32'(m_i_ce), 0);
            @(posedge m_clk);
            #1;
            if (!st) break;
            stalls++;
        end
        check("stall_cycles", stalls, exp_stall);
    endtask

    task automatic do_idle();
        l_i_rd = 1'b0;
        l_i_wr = 1'b0;
        @(negedge m_clk);
        check("idle_ce", 32'(m_i_ce), 0);
        check("idle_rd_en", 32'(m_rd_en), 0);
        check("idle_wr_en", 32'(m_wr_en), 0);
        @(posedge m_clk);
        #1;
    endtask

    // Scoreboard monitor: every DUT output event must match the oldest expectation of its kind.
    always @(negedge m_clk) begin : monitor
        exp_t e;
        if (l_o_rvalid) begin
            if (load_q.size() == 0) begin
                check("unexpected_rvalid", 32'(l_o_rvalid), 0);
            end else begin
                e = load_q.pop_front();
                check("load_data", l_o_rdata, e.data);
                check("load_latency", cyc, e.due);
            end
        end
        if (m_i_ce && m_wr_en) begin
            if (write_q.size() == 0) begin
                check("unexpected_write", 32'(m_wr_en), 0);
            end else begin
                e = write_q.pop_front();
                check("write_index", 32'(alu_value_addr), e.idx);
                check("write_data", m_i_store_data, e.data);
                check("write_cycle", cyc, e.due);
            end
        end
        if (l_o_misalign) begin
            if (mis_q.size() == 0) begin
                check("unexpected_misalign", 32'(l_o_misalign), 0);
            end else begin
                e = mis_q.pop_front();
                check("misalign_cycle", cyc, e.due);
            end
        end
        if (!m_i_ce) begin
            check("idle_addr_zero", 32'(alu_value_addr), 0);
            check("idle_store_data_zero", m_i_store_data, 0);
        end
        if (!m_rst) begin
            check("reset_ce", 32'(m_i_ce), 0);
            check("reset_rd_en", 32'(m_rd_en), 0);
            check("reset_wr_en", 32'(m_wr_en), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time budget, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] a12;
        int          kind;

        for (int i = 0; i < NWORDS; i++) begin
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = 8'(i >> (8*k));
        end

        // Reset with a request driven: memory controls must stay low.
        m_rst        = 1'b0;
        mem_load     = 1'b1;
        l_i_rd       = 1'b1;
        l_i_wr       = 1'b0;
        l_i_size     = 2'b10;
        l_i_unsigned = 1'b0;
        l_i_addr     = 32'h14;
        l_i_wdata    = 32'h0;
        repeat (2) @(posedge m_clk);
        @(negedge m_clk);
        check("reset_rdata", l_o_rdata, 0);
        check("reset_rvalid", 32'(l_o_rvalid), 0);
        check("reset_misalign", 32'(l_o_misalign), 0);
        check("reset_stall", 32'(l_o_stall), 0);
        mem_load = 1'b0;
        l_i_rd   = 1'b0;
        m_rst    = 1'b1;
        @(posedge m_clk);
        #1;

        // Word i holds i after reset.
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 32'h0000_0005);

        // Word store then signed / unsigned byte loads of the top lane.
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 1'b1, 32'hFFFF_FFDE);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 1'b1, 32'h0000_00DE);
        check("word2_after_sw", mem[2], 32'hDEAD_BEEF);

        // Half store into the upper lane of a known word: one stall cycle, low half preserved.
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_1234, 1'b0, 32'h0);
        check("word3_after_sh", mem[3], 32'h1234_BEEF);

        // Misaligned word load: traps in the trap build, reads word 1 otherwise.
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0000_0001);

        // Load and store together: the store wins, no load result.
        do_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hA5A5_A5A5, 1'b0, 32'h0);
        l_i_rd = 1'b0;
        l_i_wr = 1'b0;
        @(negedge m_clk);
        check("rdwr_no_rvalid", 32'(l_o_rvalid), 0);
        @(posedge m_clk);
        #1;
        check("word4_after_rdwr", mem[4], 32'hA5A5_A5A5);

        // Byte store aborted by reset in the write-back cycle.
        l_i_rd       = 1'b0;
        l_i_wr       = 1'b1;
        l_i_size     = 2'b00;
        l_i_unsigned = 1'b0;
        l_i_addr     = 32'h21;
        l_i_wdata    = 32'h0000_0077;
        @(negedge m_clk);
        check("rmw_enter_stall", 32'(l_o_stall), 1);
        @(posedge m_clk);
        #1;
        check("rmw_write_pending", 32'(m_wr_en), 1);
        m_rst = 1'b0;
        #1;
        check("abort_ce", 32'(m_i_ce), 0);
        check("abort_wr_en", 32'(m_wr_en), 0);
        check("abort_stall", 32'(l_o_stall), 0);
        check("abort_rdata", l_o_rdata, 0);
        repeat (2) @(negedge m_clk);
        l_i_wr = 1'b0;
        m_rst  = 1'b1;
        @(posedge m_clk);
        #1;
        check("abort_word_kept", mem[8], ref_word(8));
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'h0);

        // Random traffic over a small window so loads often hit recent stores.
        for (int it = 0; it < 300; it++) begin
            kind = int'($urandom_range(0, 9));
            size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a12 = 32'($urandom_range(0, 4095));
            else                           a12 = 32'($urandom_range(0, 63));
            addr = ($urandom() & 32'hFFFF_F000) | a12;
            if (kind == 0)
                do_idle();
            else if (kind <= 4)
                do_op(1'b1, 1'b0, size, 1'($urandom_range(0, 1)), addr, 32'h0, 1'b0, 32'h0);
            else if (kind <= 8)
                do_op(1'b0, 1'b1, size, 1'b0, addr, $urandom(), 1'b0, 32'h0);
            else
                do_op(1'b1, 1'b1, size, 1'b0, addr, $urandom(), 1'b0, 32'h0);
        end

        repeat (3) do_idle();
        check("loads_drained", load_q.size(), 0);
        check("writes_drained", write_q.size(), 0);
        check("misaligns_drained", mis_q.size(), 0);
        for (int w = 0; w < 16; w++) check("final_mem_word", mem[w], ref_word(w));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port m_clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port m_rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port l_i_rd, input, 1: load request from EX/MEM.
REQ-004 SHALL have port l_i_wr, input, 1: store request from EX/MEM.
REQ-005 SHALL have port l_i_size, input, 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
REQ-006 SHALL have port l_i_unsigned, input, 1: zero-extend (1) or sign-extend (0) sub-word loads.
REQ-007 SHALL have port l_i_addr, input, `DWIDTH: byte address from ALU.
REQ-008 SHALL have port l_i_wdata, input, `DWIDTH: store data, right-aligned.
REQ-009 SHALL have ports m_i_ce, m_rd_en, m_wr_en, outputs, 1 each: data-memory controls.
REQ-010 SHALL have port alu_value_addr, output, `AWIDTH_MEM: word index = l_i_addr[`AWIDTH_MEM+1:2].
REQ-011 SHALL have port m_i_store_data, output, `DWIDTH: word written to memory.
REQ-012 SHALL have port m_o_load_data, input, `DWIDTH: combinational word read from memory.
REQ-013 SHALL have port l_o_rdata, output, `DWIDTH: registered, extended load result.
REQ-014 SHALL have port l_o_rvalid, output, 1: one-cycle pulse, l_o_rdata valid.
REQ-015 SHALL have port l_o_stall, output, 1: pipeline must hold all l_i_* stable.
REQ-016 SHALL have port l_o_misalign, output, 1: one-cycle misalignment pulse.

Function
REQ-017 SHALL use little-endian byte lanes: offset 0 = bits[7:0], half offset 0 = bits[15:0].
REQ-018 SHALL implement FSM IDLE, RMW; reset state IDLE.
REQ-019 Load in IDLE SHALL assert m_i_ce, m_rd_en that cycle; next edge registers the extracted lane into l_o_rdata, extended per l_i_unsigned, and pulses l_o_rvalid; latency 1, no stall.
REQ-020 Word store in IDLE SHALL assert m_i_ce, m_wr_en with m_i_store_data = l_i_wdata the same cycle; no stall.
REQ-021 Byte/half store in IDLE SHALL assert m_i_ce, m_rd_en, l_o_stall, capture m_o_load_data into a merge register on the edge, and enter RMW.
REQ-022 In RMW SHALL assert m_i_ce, m_wr_en, l_o_stall=0, with m_i_store_data = merge register with addressed lane replaced by l_i_wdata low byte/half; return to IDLE next edge.
REQ-023 l_i_rd and l_i_wr both high SHALL be treated as a store; the load is dropped, l_o_rvalid stays 0.
REQ-024 No request SHALL drive m_i_ce, m_rd_en, m_wr_en low and l_o_rvalid 0 next cycle.
REQ-025 New requests SHALL be ignored in RMW; the pending store completes first.
REQ-026 Outputs alu_value_addr and m_i_store_data SHALL be 0 when m_i_ce is 0.

Reset
REQ-027 m_rst low SHALL immediately force IDLE, l_o_rdata=0, l_o_rvalid=0, merge register=0, l_o_misalign=0.
REQ-028 Reset in RMW SHALL abort the store; no memory write occurs.
REQ-029 Memory controls SHALL be 0 while m_rst is low.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL perform no access (m_i_ce=0) and pulse l_o_misalign next cycle.
REQ-031 Without LSU_MISALIGN_TRAP_EN: l_o_misalign SHALL be tied 0; half ignores addr[0], word ignores addr[1:0].

Structure
REQ-032 Size encodings, FSM state encodings, lane-mask widths SHALL live in the shared header.vh alongside `DWIDTH, `AWIDTH_MEM.
REQ-033 Lane extraction/extension SHALL be a sub-module lsu_load_align; merge logic stays inline.

Verification
REQ-034 After reset, memory word i holds i: lw addr 0x14 -> l_o_rdata=0x00000005, rvalid one cycle later.
REQ-035 sw 0xDEADBEEF to 0x08 then lb 0x0B signed -> 0xFFFFFFDE; lbu -> 0x000000DE.
REQ-036 sh 0x1234 to 0x0E over 0xDEADBEEF at word 3 -> stall exactly 1 cycle, word 3 = 0x1234BEEF.
REQ-037 sb in progress, m_rst pulsed in RMW -> no write, word unchanged, FSM IDLE.
REQ-038 Trap build, lw 0x06 -> m_i_ce=0, l_o_misalign pulse; non-trap build -> reads word 1.
REQ-039 l_i_rd=l_i_wr=1 word at 0x10, data 0xA5A5A5A5 -> word 4 written, l_o_rvalid stays 0.
